// File: rtl/ioctl_upload_reader.sv
// HPS upload read-back: serves ioctl reads from the shared cartridge dpram port,
// stalling the HPS with ioctl_wait and padding reads past the end of the image.
module ioctl_upload_reader #(
  parameter int          AW     = 15,
  parameter int          RD_LAT = 1,
  parameter logic [7:0]  PAD    = 8'hFF
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_upload,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  input  logic [AW:0]   data_size,
  input  logic          mem_busy,
  input  logic [7:0]    mem_q,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic [AW:0]   byte_count,
  output logic          upload_done,
  output logic          err_overrun
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARB   = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_LAT   = 3'd3;
  localparam logic [2:0] S_CAP   = 3'd4;

  // LAT occupies RD_LAT-1 cycles; the counter holds the remaining extra cycles
  localparam logic [1:0] LAT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  logic [2:0]    state;
  logic [1:0]    lat_cnt;
  logic [AW-1:0] addr_q;
  logic          upload_d;
  logic [7:0]    din_q;
  logic [AW:0]   count_q;
  logic          done_q;
  logic          err_q;

  logic          strobe;
  logic          in_range;
  logic          rise;
  logic          fall;
  logic          count_inc;
  logic [AW:0]   count_base;
  logic [AW:0]   count_next;

  assign strobe   = ioctl_upload & ioctl_rd;
  assign in_range = ioctl_addr < 25'(data_size);
  assign rise     = ioctl_upload & ~upload_d;
  assign fall     = ~ioctl_upload & upload_d;

  // A read completing in the same cycle the session restarts counts into the new session
  always_comb begin
    count_inc  = ((state == S_IDLE) & strobe & ~in_range) | ((state == S_CAP) & ~fall);
    count_base = rise ? '0 : count_q;
    count_next = count_base;
    if (count_inc && (count_base != '1))
      count_next = count_base + 1'b1;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      lat_cnt  <= '0;
      addr_q   <= '0;
      upload_d <= 1'b0;
      din_q    <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      upload_d <= ioctl_upload;
      done_q   <= fall;
      count_q  <= count_next;

      if (rise)
        err_q <= 1'b0;
      else if (strobe && (state != S_IDLE))
        err_q <= 1'b1;

      if (fall) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (strobe) begin
              addr_q <= ioctl_addr[AW-1:0];
              if (in_range) state <= S_ARB;
              else          din_q <= PAD;
            end
          end
          S_ARB: begin
            if (!mem_busy) state <= S_ISSUE;
          end
          S_ISSUE: begin
            if (RD_LAT > 1) begin
              state   <= S_LAT;
              lat_cnt <= LAT_INIT;
            end else begin
              state <= S_CAP;
            end
          end
          S_LAT: begin
            if (lat_cnt == 2'd0) state <= S_CAP;
            else                 lat_cnt <= lat_cnt - 2'd1;
          end
          S_CAP: begin
            din_q <= mem_q;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign ioctl_wait  = (state != S_IDLE) | (strobe & in_range);
  assign mem_rd      = (state == S_ISSUE);
  assign mem_addr    = addr_q;
  assign ioctl_din   = din_q;
  assign byte_count  = count_q;
  assign upload_done = done_q;
  assign err_overrun = err_q;

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Directed bench for ioctl_upload_reader: two instances (read latency 1 and 3) driven
// through one stimulus path; expected bytes go through a scoreboard queue.
module tb_ioctl_upload_reader;

  logic        clk_sys = 1'b0;
  logic        rst_n, rst3_n;
  logic        upload;
  logic        rd_drv;
  logic [24:0] addr_drv;
  logic [15:0] data_size;
  logic        busy;
  logic        sel;

  logic        rd1, rd3;
  logic [7:0]  q1, din1, din3;
  logic [7:0]  p3 [3];
  logic        wait1, wait3, mem_rd1, mem_rd3, done1, done3, err1, err3;
  logic [14:0] mem_addr1, mem_addr3;
  logic [15:0] count1, count3;

  logic [7:0]  o_din;
  logic        o_wait, o_mem_rd, o_done, o_err;
  logic [14:0] o_mem_addr;
  logic [15:0] o_count;

  int          checks = 0;
  int          errors = 0;
  int          exp_cnt = 0;
  logic [7:0]  sb [$];

  always #5 clk_sys = ~clk_sys;

  assign rd1 = rd_drv & ~sel;
  assign rd3 = rd_drv & sel;

  ioctl_upload_reader #(.AW(15), .RD_LAT(1), .PAD(8'hFF)) dut1 (
    .clk_sys(clk_sys), .reset_n(rst_n), .ioctl_upload(upload), .ioctl_rd(rd1),
    .ioctl_addr(addr_drv), .data_size(data_size), .mem_busy(busy), .mem_q(q1),
    .ioctl_din(din1), .ioctl_wait(wait1), .mem_addr(mem_addr1), .mem_rd(mem_rd1),
    .byte_count(count1), .upload_done(done1), .err_overrun(err1));

  ioctl_upload_reader #(.AW(15), .RD_LAT(3), .PAD(8'hFF)) dut3 (
    .clk_sys(clk_sys), .reset_n(rst3_n), .ioctl_upload(upload), .ioctl_rd(rd3),
    .ioctl_addr(addr_drv), .data_size(data_size), .mem_busy(busy), .mem_q(p3[2]),
    .ioctl_din(din3), .ioctl_wait(wait3), .mem_addr(mem_addr3), .mem_rd(mem_rd3),
    .byte_count(count3), .upload_done(done3), .err_overrun(err3));

  function automatic logic [7:0] mem_byte(input logic [14:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // dpram models; 8'hEE marks data that is not the answer to a real request
  always @(posedge clk_sys) begin
    q1    <= mem_rd1 ? mem_byte(mem_addr1) : 8'hEE;
    p3[0] <= mem_rd3 ? mem_byte(mem_addr3) : 8'hEE;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  assign o_din      = sel ? din3      : din1;
  assign o_wait     = sel ? wait3     : wait1;
  assign o_mem_rd   = sel ? mem_rd3   : mem_rd1;
  assign o_mem_addr = sel ? mem_addr3 : mem_addr1;
  assign o_count    = sel ? count3    : count1;
  assign o_done     = sel ? done3     : done1;
  assign o_err      = sel ? err3      : err1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_din"},   o_din, 0);
    check({tag, "_wait"},  o_wait, 0);
    check({tag, "_memrd"}, o_mem_rd, 0);
    check({tag, "_maddr"}, o_mem_addr, 0);
    check({tag, "_count"}, o_count, 0);
    check({tag, "_done"},  o_done, 0);
    check({tag, "_err"},   o_err, 0);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Strobe one read next cycle (T); optional second strobe at T+1; track completion
  task automatic run_read(input logic [24:0] a, input bit dbl, input int exp_done,
                          input int exp_rd_at);
    logic        in_r;
    logic [14:0] a_lo;
    logic [14:0] rd_addr = '0;
    logic [7:0]  exp_din;
    int          done_at = -1;
    int          rd_at = -1;
    int          rd_n = 0;
    in_r = a < {9'd0, data_size};
    a_lo = a[14:0];
    sb.push_back(in_r ? mem_byte(a_lo) : 8'hFF);
    tick();
    rd_drv   = 1'b1;
    addr_drv = a;
    @(negedge clk_sys);
    check("wait_strobe", o_wait, in_r);
    for (int n = 1; n <= 40 && done_at < 0; n++) begin
      tick();
      rd_drv = dbl && (n == 1);
      if (dbl) addr_drv = a + 25'd2;
      @(negedge clk_sys);
      if (o_mem_rd) begin
        rd_n++;
        if (rd_at < 0) begin
          rd_at   = n;
          rd_addr = o_mem_addr;
        end
      end
      if (!o_wait) done_at = n;
    end
    rd_drv = 1'b0;
    check("done_at", done_at, exp_done);
    check("mem_rd_at", rd_at, exp_rd_at);
    check("mem_rd_n", rd_n, (exp_rd_at < 0) ? 0 : 1);
    if (exp_rd_at >= 0) check("mem_addr", rd_addr, a_lo);
    exp_din = sb.pop_front();
    check("din", o_din, exp_din);
    if (done_at > 0) exp_cnt++;
    check("count", o_count, exp_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rst3_n = 1'b0; upload = 1'b0; rd_drv = 1'b0; addr_drv = '0;
    data_size = 16'd16; busy = 1'b0; sel = 1'b0;
    #2;
    check_zero("reset");
    repeat (2) @(posedge clk_sys);
    #1;
    rst_n = 1'b1; rst3_n = 1'b1;
    tick();
    upload = 1'b1;
    tick();

    // plain in-range read, latency 1
    run_read(25'd3, 1'b0, 4, 2);

    // arbitration hold: busy over T+1..T+5
    fork
      run_read(25'd3, 1'b0, 9, 7);
      begin
        repeat (2) @(posedge clk_sys);
        #1 busy = 1'b1;
        repeat (5) @(posedge clk_sys);
        #1 busy = 1'b0;
      end
    join

    // overlapping strobe is flagged, first request still served
    run_read(25'd5, 1'b1, 4, 2);
    check("err_overrun", o_err, 1);

    // session drop while arbitrating
    tick();
    rd_drv = 1'b1; addr_drv = 25'd2; busy = 1'b1;
    tick();
    rd_drv = 1'b0;
    @(negedge clk_sys);
    check("abort_wait_arb", o_wait, 1);
    tick();
    upload = 1'b0;
    @(negedge clk_sys);
    check("abort_wait_fall", o_wait, 1);
    check("abort_memrd_fall", o_mem_rd, 0);
    tick();
    rd_drv = 1'b1; addr_drv = 25'd3;
    @(negedge clk_sys);
    check("abort_wait_after", o_wait, 0);
    check("abort_done", o_done, 1);
    check("abort_memrd", o_mem_rd, 0);
    check("abort_din", o_din, 8'h5F);
    check("abort_count", o_count, exp_cnt);
    tick();
    rd_drv = 1'b0; busy = 1'b0;
    @(negedge clk_sys);
    check("done_pulse_end", o_done, 0);
    check("idle_rd_no_err", o_err, 1);
    check("idle_rd_din", o_din, 8'h5F);
    check("idle_rd_count", o_count, exp_cnt);

    // new session clears count and error
    tick();
    upload = 1'b1;
    tick();
    @(negedge clk_sys);
    exp_cnt = 0;
    check("restart_count", o_count, 0);
    check("restart_err", o_err, 0);

    // past end of image, including a high address that aliases in range
    run_read(25'd16, 1'b0, 1, -1);
    run_read(25'h100000, 1'b0, 1, -1);
    data_size = 16'd0;
    run_read(25'd0, 1'b0, 1, -1);
    data_size = 16'd16;

    // latency-3 instance: async reset in the middle of LAT
    sel = 1'b1;
    exp_cnt = 0;
    tick();
    rd_drv = 1'b1; addr_drv = 25'd9;
    tick();
    rd_drv = 1'b0;
    tick();
    @(negedge clk_sys);
    check("lat3_memrd", o_mem_rd, 1);
    @(posedge clk_sys);
    #2;
    check("lat3_in_lat_wait", o_wait, 1);
    rst3_n = 1'b0;
    #1;
    check_zero("async_rst");
    tick();
    check_zero("held_rst");
    rst3_n = 1'b1;
    run_read(25'd9, 1'b0, 6, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
